stm_swapchain_multi: RTL and testbench
======================================

// Module: stm_swapchain_multi
// PURPOSE
//  Parametrised N-segment STM swapchain. Selects the active STM segment and counts finite repeats of it.
//  A transition takes effect in one of three modes: immediately, on index wrap, or on an external trigger.
//  Sits between the settings/controller interface and the per-segment STM index generators.
//  Drives SEGMENT and STOP to the STM output mux and forwards registered indices.
// PARAMETERS
//  NUM_SEGMENTS  2   number of STM segments; legal range 2..16
//  SEG_W         $clog2(NUM_SEGMENTS)   segment select width (derived; min 1)
//  IDX_W         16  per-segment index width
//  REP_W         32  repeat-count width; all-ones means infinite
// PORTS
//  CLK              in   1                     system clock
//  RST_N            in   1                     async active-low reset
//  UPDATE_SETTINGS  in   1                     1-cycle strobe; latch new request
//  REQ_SEGMENT      in   SEG_W                 requested segment
//  REQ_MODE         in   2                     0 IMMEDIATE, 1 SYNC_IDX, 2 EXT_TRIG, 3 = IMMEDIATE
//  REP              in   NUM_SEGMENTS*REP_W    per-segment repeat count; seg k at [k*REP_W +: REP_W]
//  IDX_IN           in   NUM_SEGMENTS*IDX_W    per-segment live index, packed as REP
//  EXT_TRIG         in   1                     external trigger, already synchronised; rising edge used
//  SEGMENT          out  SEG_W                 active segment
//  STOP             out  1                     finite repeat exhausted
//  PENDING          out  1                     transition armed, waiting for its condition
//  LOOP_CNT         out  REP_W                 completed wraps in current finite run
//  IDX_OUT          out  NUM_SEGMENTS*IDX_W    IDX_IN delayed 1 cycle
// BEHAVIOUR
//  Reset: SEGMENT=0, STOP=0, PENDING=0, LOOP_CNT=0, IDX_OUT=0, trig_q=0, state=INFINITE_LOOP.
//  States: INFINITE_LOOP, WAIT_START, FINITE_LOOP.
//  UPDATE_SETTINGS has priority over every state action in the same cycle:
//   - REQ_SEGMENT >= NUM_SEGMENTS: request ignored; no state or output change.
//   - REQ_SEGMENT == SEGMENT: STOP<=0, PENDING<=0, state<=INFINITE_LOOP. Cancels any armed request.
//   - Otherwise: latch req_seg, mode, rep=REP[req_seg]; PENDING<=1; state<=WAIT_START.
//     An earlier armed request is replaced.
//  WAIT_START: fire when the condition holds. The condition is evaluated from the cycle after the strobe.
//   - IMMEDIATE: always true; fires the cycle after the strobe.
//   - SYNC_IDX: idx[req_seg]==0.
//   - EXT_TRIG: EXT_TRIG & ~trig_q. trig_q registers EXT_TRIG every cycle.
//  On fire: SEGMENT<=req_seg, STOP<=0, LOOP_CNT<=0, PENDING<=0.
//   - Next state is INFINITE_LOOP if rep is all-ones, else FINITE_LOOP.
//   - STOP keeps its old value while waiting.
//  FINITE_LOOP: wrap = idx[SEGMENT] != IDX_OUT[SEGMENT] && idx[SEGMENT]==0.
//   - On wrap: if LOOP_CNT==rep, STOP<=1; else LOOP_CNT<=LOOP_CNT+1.
//   - Total passes = rep+1; rep=0 stops at the first wrap.
//   - STOP is sticky; wraps are ignored while STOP=1. LOOP_CNT never exceeds rep and never wraps.
//  INFINITE_LOOP: holds; STOP and LOOP_CNT are unchanged.
//  Only the active segment's wraps are counted. Other segments' indices are only forwarded.
//  Latency: SEGMENT, STOP and PENDING are registered, 1 cycle after the causing edge; IDX_OUT is 1 cycle.
//  Reset asserted mid-wait or mid-count returns every output to its reset value immediately (async).
// STRUCTURE
//  stm_swapchain_pkg: mode_t enum (IMMEDIATE, SYNC_IDX, EXT_TRIG) and state_t enum.
//   - Also holds the helper function rep_inf(rep) that returns rep=='1.
//  Sub-module stm_wrap_detect (IDX_W): registered idx_q plus a wrap pulse.
//   - Instantiated once per segment with a generate loop; IDX_OUT is built from the idx_q outputs.
// TESTING
//  1. Reset, then UPD seg=1 mode=IMM REP[1]=all-ones -> SEGMENT=1 two cycles after the strobe; PENDING pulses 1 cycle; STOP=0.
//  2. Seg0 active, UPD seg=1 SYNC_IDX rep=2, idx1 runs 5..9,0.. -> switch at idx1==0; STOP=1 at the 3rd wrap after entry; LOOP_CNT=2.
//  3. NUM_SEGMENTS=4, UPD seg=3 EXT_TRIG -> waits while EXT_TRIG stays high from before; switches on the next 0->1 edge only.
//  4. While PENDING for seg=2, UPD seg=1 IMM -> seg2 is never selected; SEGMENT=1.
//  5. UPD seg=4 with NUM_SEGMENTS=4 -> no change. UPD to the current segment while STOP=1 -> STOP=0, INFINITE_LOOP.
//  6. RST_N low mid FINITE_LOOP (LOOP_CNT=1) -> all outputs 0 asynchronously; after release, wraps do not increment LOOP_CNT.

Source files
------------

// File: rtl/stm_swapchain_pkg.sv
// Shared types and helpers for the STM swapchain: transition modes, FSM states,
// and the infinite-repeat test.
package stm_swapchain_pkg;

  typedef enum logic [1:0] {
    MODE_IMMEDIATE = 2'd0,
    MODE_SYNC_IDX  = 2'd1,
    MODE_EXT_TRIG  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    INFINITE_LOOP = 2'd0,
    WAIT_START    = 2'd1,
    FINITE_LOOP   = 2'd2
  } state_t;

  localparam int REP_W_MAX = 64;

  // Encoding 3 is reserved on the interface and behaves as IMMEDIATE.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_SYNC_IDX;
      2'd2:    return MODE_EXT_TRIG;
      default: return MODE_IMMEDIATE;
    endcase
  endfunction

  // True when the low 'width' bits of rep are all ones (infinite repeat).
  function automatic logic rep_inf(input logic [REP_W_MAX-1:0] rep, input int width);
    logic all_ones;
    all_ones = 1'b1;
    for (int i = 0; i < REP_W_MAX; i++) begin
      if (i < width && !rep[i]) all_ones = 1'b0;
    end
    return all_ones;
  endfunction

endpackage

// File: rtl/stm_wrap_detect.sv
// Per-segment index register plus a wrap pulse when the live index returns to
// zero from a different value.
module stm_wrap_detect #(
  parameter int IDX_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_q,
  output logic             wrap
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) idx_q <= '0;
    else        idx_q <= idx;
  end

  // Edge-style detect: an index parked at zero produces a single wrap.
  assign wrap = (idx != idx_q) && (idx == '0);

endmodule

// File: rtl/stm_swapchain_multi.sv
// N-segment STM swapchain: selects the active segment, arms transitions in one
// of three modes, and counts finite repeats of the active segment.
module stm_swapchain_multi
  import stm_swapchain_pkg::*;
#(
  parameter int NUM_SEGMENTS = 2,
  parameter int SEG_W        = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1,
  parameter int IDX_W        = 16,
  parameter int REP_W        = 32
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          UPDATE_SETTINGS,
  input  logic [SEG_W-1:0]              REQ_SEGMENT,
  input  logic [1:0]                    REQ_MODE,
  input  logic [NUM_SEGMENTS*REP_W-1:0] REP,
  input  logic [NUM_SEGMENTS*IDX_W-1:0] IDX_IN,
  input  logic                          EXT_TRIG,
  output logic [SEG_W-1:0]              SEGMENT,
  output logic                          STOP,
  output logic                          PENDING,
  output logic [REP_W-1:0]              LOOP_CNT,
  output logic [NUM_SEGMENTS*IDX_W-1:0] IDX_OUT,
  output logic [1:0]                    STATE_DBG
);

  // UPDATE_SETTINGS is a single-cycle strobe with no back-pressure: the request
  // fields are sampled on the clock edge where it is high and never held off.

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [SEG_W-1:0]   seg_q, seg_d, req_seg_q, req_seg_d;
  logic [REP_W-1:0]   rep_q, rep_d, cnt_q, cnt_d;
  logic               stop_q, stop_d, pend_q, pend_d;
  logic               trig_q, fire, req_valid;

  logic [IDX_W-1:0]        idx_live [NUM_SEGMENTS];
  logic [REP_W-1:0]        rep_arr  [NUM_SEGMENTS];
  logic [NUM_SEGMENTS-1:0] wrap_vec;

  for (genvar k = 0; k < NUM_SEGMENTS; k++) begin : g_seg
    assign idx_live[k] = IDX_IN[k*IDX_W +: IDX_W];
    assign rep_arr[k]  = REP[k*REP_W +: REP_W];
    stm_wrap_detect #(.IDX_W(IDX_W)) u_wrap (
      .CLK   (CLK),
      .RST_N (RST_N),
      .idx   (idx_live[k]),
      .idx_q (IDX_OUT[k*IDX_W +: IDX_W]),
      .wrap  (wrap_vec[k])
    );
  end

  assign req_valid = int'(REQ_SEGMENT) < NUM_SEGMENTS;

  always_comb begin
    case (mode_q)
      MODE_SYNC_IDX: fire = (idx_live[req_seg_q] == '0);
      MODE_EXT_TRIG: fire = EXT_TRIG & ~trig_q;
      default:       fire = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= INFINITE_LOOP;
      mode_q    <= MODE_IMMEDIATE;
      seg_q     <= '0;
      req_seg_q <= '0;
      rep_q     <= '0;
      cnt_q     <= '0;
      stop_q    <= 1'b0;
      pend_q    <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      seg_q     <= seg_d;
      req_seg_q <= req_seg_d;
      rep_q     <= rep_d;
      cnt_q     <= cnt_d;
      stop_q    <= stop_d;
      pend_q    <= pend_d;
      trig_q    <= EXT_TRIG;
    end
  end

  // A valid strobe overrides whatever the current state would have done.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    seg_d     = seg_q;
    req_seg_d = req_seg_q;
    rep_d     = rep_q;
    cnt_d     = cnt_q;
    stop_d    = stop_q;
    pend_d    = pend_q;
    if (UPDATE_SETTINGS && req_valid) begin
      if (REQ_SEGMENT == seg_q) begin
        stop_d  = 1'b0;
        pend_d  = 1'b0;
        state_d = INFINITE_LOOP;
      end else begin
        req_seg_d = REQ_SEGMENT;
        mode_d    = decode_mode(REQ_MODE);
        rep_d     = rep_arr[REQ_SEGMENT];
        pend_d    = 1'b1;
        state_d   = WAIT_START;
      end
    end else begin
      case (state_q)
        WAIT_START: begin
          if (fire) begin
            seg_d   = req_seg_q;
            stop_d  = 1'b0;
            cnt_d   = '0;
            pend_d  = 1'b0;
            state_d = rep_inf(REP_W_MAX'(rep_q), REP_W) ? INFINITE_LOOP : FINITE_LOOP;
          end
        end
        FINITE_LOOP: begin
          if (!stop_q && wrap_vec[seg_q]) begin
            if (cnt_q == rep_q) stop_d = 1'b1;
            else                cnt_d  = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    SEGMENT   = seg_q;
    STOP      = stop_q;
    PENDING   = pend_q;
    LOOP_CNT  = cnt_q;
    STATE_DBG = state_q;
  end

endmodule

// File: tb/tb_stm_swapchain_multi.sv
// Self-checking bench for stm_swapchain_multi with three segments, so that an
// out-of-range request (segment 3) is representable on the 2-bit select.
module tb_stm_swapchain_multi;

  localparam int N     = 3;
  localparam int SEG_W = 2;
  localparam int IDX_W = 16;
  localparam int REP_W = 32;

  localparam logic [1:0] ST_INF  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic                   CLK = 1'b0;
  logic                   RST_N = 1'b1;
  logic                   UPDATE_SETTINGS = 1'b0;
  logic [SEG_W-1:0]       REQ_SEGMENT = '0;
  logic [1:0]             REQ_MODE = '0;
  logic [N*REP_W-1:0]     REP = '1;
  logic [N*IDX_W-1:0]     IDX_IN = '0;
  logic                   EXT_TRIG = 1'b0;
  logic [SEG_W-1:0]       SEGMENT;
  logic                   STOP;
  logic                   PENDING;
  logic [REP_W-1:0]       LOOP_CNT;
  logic [N*IDX_W-1:0]     IDX_OUT;
  logic [1:0]             STATE_DBG;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N*IDX_W-1:0] exp_q[$];
  logic [SEG_W-1:0]   seg_exp_q[$];
  logic [SEG_W-1:0]   seg_prev = '0;
  int                 idx_v [N] = '{0, 0, 0};

  stm_swapchain_multi #(
    .NUM_SEGMENTS (N),
    .SEG_W        (SEG_W),
    .IDX_W        (IDX_W),
    .REP_W        (REP_W)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .UPDATE_SETTINGS (UPDATE_SETTINGS),
    .REQ_SEGMENT     (REQ_SEGMENT),
    .REQ_MODE        (REQ_MODE),
    .REP             (REP),
    .IDX_IN          (IDX_IN),
    .EXT_TRIG        (EXT_TRIG),
    .SEGMENT         (SEGMENT),
    .STOP            (STOP),
    .PENDING         (PENDING),
    .LOOP_CNT        (LOOP_CNT),
    .IDX_OUT         (IDX_OUT),
    .STATE_DBG       (STATE_DBG)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_idx(input int k, input int v);
    idx_v[k] = v;
    IDX_IN[k*IDX_W +: IDX_W] = IDX_W'(v);
  endtask

  task automatic set_rep(input int k, input logic [REP_W-1:0] v);
    REP[k*REP_W +: REP_W] = v;
  endtask

  task automatic strobe(input logic [SEG_W-1:0] seg, input logic [1:0] mode);
    UPDATE_SETTINGS = 1'b1;
    REQ_SEGMENT     = seg;
    REQ_MODE        = mode;
    tick(1);
    UPDATE_SETTINGS = 1'b0;
  endtask

  // Advance segment k's index modulo 'period'; the next segment runs a short
  // ramp as background traffic that must never be counted.
  task automatic step_seg(input int k, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      set_idx(k, (idx_v[k] + 1) % period);
      set_idx((k + 1) % N, (idx_v[(k + 1) % N] + 1) % 3);
      tick(1);
    end
  endtask

  task automatic check_state(input string tag, input logic [SEG_W-1:0] seg, input logic stop,
                             input logic pend, input logic [REP_W-1:0] cnt, input logic [1:0] st);
    check({tag, "_seg"},   SEGMENT,   seg);
    check({tag, "_stop"},  STOP,      stop);
    check({tag, "_pend"},  PENDING,   pend);
    check({tag, "_cnt"},   LOOP_CNT,  cnt);
    check({tag, "_state"}, STATE_DBG, st);
  endtask

  // Scoreboard: IDX_OUT must equal the previous cycle's IDX_IN, and every
  // SEGMENT change must match the next expected switch pushed by the stimulus.
  always @(negedge CLK) begin
    if (!RST_N) begin
      exp_q.delete();
      seg_prev = '0;
    end else begin
      if (exp_q.size() > 0) check("idx_out", IDX_OUT, exp_q.pop_front());
      exp_q.push_back(IDX_IN);
      if (SEGMENT != seg_prev) begin
        if (seg_exp_q.size() == 0) check("seg_unexpected", SEGMENT, seg_prev);
        else                       check("seg_switch", SEGMENT, seg_exp_q.pop_front());
        seg_prev = SEGMENT;
      end
    end
  end

  initial begin
    #2 RST_N = 1'b0;
    tick(3);
    check_state("reset", 0, 0, 0, 0, ST_INF);
    check("reset_idx_out", IDX_OUT, 0);
    RST_N = 1'b1;
    tick(1);

    // Immediate switch to an infinite segment
    seg_exp_q.push_back(2'd1);
    strobe(2'd1, 2'd0);
    check_state("imm_armed", 0, 0, 1, 0, ST_WAIT);
    tick(1);
    check_state("imm_fired", 1, 0, 0, 0, ST_INF);

    // Back to seg0 using the reserved mode encoding, which acts as immediate
    seg_exp_q.push_back(2'd0);
    strobe(2'd0, 2'd3);
    tick(1);
    check_state("mode3_fired", 0, 0, 0, 0, ST_INF);

    // SYNC_IDX to seg1 with rep=2: switch when idx1 returns to 0
    set_rep(1, 32'd2);
    set_idx(1, 5);
    seg_exp_q.push_back(2'd1);
    strobe(2'd1, 2'd1);
    check_state("sync_armed", 0, 0, 1, 0, ST_WAIT);
    step_seg(1, 4, 10);
    check_state("sync_wait", 0, 0, 1, 0, ST_WAIT);
    step_seg(1, 1, 10);
    check_state("sync_fired", 1, 0, 0, 0, ST_FIN);
    step_seg(1, 10, 10);
    check_state("wrap1", 1, 0, 0, 1, ST_FIN);
    step_seg(1, 10, 10);
    check_state("wrap2", 1, 0, 0, 2, ST_FIN);
    step_seg(1, 9, 10);
    check_state("pre_wrap3", 1, 0, 0, 2, ST_FIN);
    step_seg(1, 1, 10);
    check_state("wrap3_stop", 1, 1, 0, 2, ST_FIN);
    step_seg(1, 10, 10);
    check_state("stop_sticky", 1, 1, 0, 2, ST_FIN);

    // Out-of-range request is ignored; same-segment request clears STOP
    strobe(2'd3, 2'd0);
    check_state("bad_seg", 1, 1, 0, 2, ST_FIN);
    strobe(2'd1, 2'd0);
    check_state("same_seg", 1, 0, 0, 2, ST_INF);
    step_seg(1, 10, 10);
    check_state("inf_hold", 1, 0, 0, 2, ST_INF);

    // EXT_TRIG to seg2: a level held from before must not fire
    set_rep(2, '1);
    EXT_TRIG = 1'b1;
    tick(2);
    seg_exp_q.push_back(2'd2);
    strobe(2'd2, 2'd2);
    tick(4);
    check_state("trig_high_wait", 1, 0, 1, 2, ST_WAIT);
    EXT_TRIG = 1'b0;
    tick(2);
    check_state("trig_low_wait", 1, 0, 1, 2, ST_WAIT);
    EXT_TRIG = 1'b1;
    tick(1);
    check_state("trig_fired", 2, 0, 0, 0, ST_INF);

    // A pending SYNC request for seg0 is replaced by an immediate one for seg1
    set_idx(0, 7);
    strobe(2'd0, 2'd1);
    check_state("pend_seg0", 2, 0, 1, 0, ST_WAIT);
    seg_exp_q.push_back(2'd1);
    strobe(2'd1, 2'd0);
    check_state("replaced", 2, 0, 1, 0, ST_WAIT);
    tick(1);
    check_state("replace_fired", 1, 0, 0, 0, ST_FIN);
    set_idx(0, 0);
    tick(3);
    check_state("seg0_never", 1, 0, 0, 0, ST_FIN);

    // Async reset in the middle of a finite run
    set_idx(1, 1);
    tick(1);
    step_seg(1, 9, 10);
    check_state("pre_reset", 1, 0, 0, 1, ST_FIN);
    #2 RST_N = 1'b0;
    #1;
    check_state("async_reset", 0, 0, 0, 0, ST_INF);
    check("async_reset_idx_out", IDX_OUT, 0);
    tick(1);
    RST_N = 1'b1;
    tick(1);
    step_seg(0, 25, 10);
    check_state("post_reset", 0, 0, 0, 0, ST_INF);

    tick(2);
    check("seg_sb_drained", seg_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
